// File: rtl/difftest_pkg.sv
// difftest_pkg: shared constants, header layout and FSM states for the difftest stream packer.
package difftest_pkg;

    localparam logic [15:0] MAGIC_WORD = 16'hDA7A;

    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] seq;
    } hdr_t;

    typedef enum logic {IDLE, SEND} state_e;

    function automatic int calc_beats(input int in_w, input int hdr_w, input int axis_w);
        return (in_w + hdr_w) / axis_w;
    endfunction

endpackage

// File: rtl/difftest_axis_packer.sv
// difftest_axis_packer: packs headered commit records into AXIS beats, one active slot plus one pending slot.
module difftest_axis_packer
    import difftest_pkg::*;
#(
    parameter int          IN_WIDTH      = 4064,
    parameter int          AXIS_WIDTH    = 512,
    parameter int          HDR_WIDTH     = 32,
    parameter logic [15:0] MAGIC         = MAGIC_WORD,
    parameter int          PKTS_PER_XFER = 8
) (
    input  logic                    xdma_clk,
    input  logic                    xdma_resetn,
    input  logic                    in_valid,
    input  logic [IN_WIDTH-1:0]     in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [AXIS_WIDTH-1:0]   m_axis_c2h_tdata_0,
    output logic [AXIS_WIDTH/8-1:0] m_axis_c2h_tkeep_0,
    output logic                    m_axis_c2h_tlast_0,
    output logic                    m_axis_c2h_tvalid_0,
    input  logic                    m_axis_c2h_tready_0,
    output logic [31:0]             pkt_count,
    output logic                    busy
);

    localparam int BEATS = calc_beats(IN_WIDTH, HDR_WIDTH, AXIS_WIDTH);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    state_e state_q, state_d;
    logic [BEATS-1:0][AXIS_WIDTH-1:0] act_q, act_d, pend_q, pend_d, pkt;
    logic pend_vld_q, pend_vld_d, flush_pend_q, flush_pend_d, tlast_q, tlast_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] grp_q, grp_d, pkt_count_q, pkt_count_d;
    logic acc, hs, last_hs, tvalid;
    hdr_t hdr;

    assign in_ready = !pend_vld_q;
    assign tvalid   = state_q == SEND;
    assign acc      = in_valid && in_ready;
    assign hs       = tvalid && m_axis_c2h_tready_0;
    assign last_hs  = hs && beat_q == BW'(BEATS - 1);
    assign hdr      = '{magic: MAGIC, seq: seq_q};
    assign pkt      = {in_data, hdr};

    assign m_axis_c2h_tvalid_0 = tvalid;
    assign m_axis_c2h_tkeep_0  = {(AXIS_WIDTH/8){tvalid}};
    assign m_axis_c2h_tlast_0  = tlast_q;
    assign pkt_count           = pkt_count_q;
    assign busy                = tvalid || pend_vld_q;

    always_comb begin
        m_axis_c2h_tdata_0 = '0;
        for (int i = 0; i < BEATS; i++)
            if (beat_q == BW'(i)) m_axis_c2h_tdata_0 = act_q[i];
    end

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        beat_d       = beat_q;
        seq_d        = acc ? seq_q + 16'd1 : seq_q;
        grp_d        = grp_q;
        pkt_count_d  = pkt_count_q;
        flush_pend_d = flush_pend_q | flush;
        if (state_q == IDLE) begin
            if (acc) begin
                act_d   = pkt;
                beat_d  = '0;
                state_d = SEND;
            end
        end else if (last_hs) begin
            pkt_count_d = pkt_count_q + 32'd1;
            grp_d       = tlast_q ? '0 : grp_q + 32'd1;
            // a flush arriving with the closing beat belongs to the next transfer
            if (tlast_q) flush_pend_d = flush;
            beat_d      = '0;
            act_d       = pend_vld_q ? pend_q : pkt;
            pend_vld_d  = 1'b0;
            state_d     = (pend_vld_q || acc) ? SEND : IDLE;
        end else begin
            if (hs) beat_d = beat_q + 1'b1;
            if (acc) begin
                pend_d     = pkt;
                pend_vld_d = 1'b1;
            end
        end
        // tlast is decided when a beat is presented and frozen while the sink stalls
        tlast_d = (state_q == SEND && !hs) ? tlast_q :
                  (state_d == SEND && beat_d == BW'(BEATS - 1) &&
                   (grp_d == 32'(PKTS_PER_XFER - 1) || flush_pend_d));
    end

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            state_q      <= IDLE;
            act_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            tlast_q      <= 1'b0;
            beat_q       <= '0;
            seq_q        <= '0;
            grp_q        <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            flush_pend_q <= flush_pend_d;
            tlast_q      <= tlast_d;
            beat_q       <= beat_d;
            seq_q        <= seq_d;
            grp_q        <= grp_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_difftest_axis_packer.sv
// tb_difftest_axis_packer: randomized scoreboard bench; a second instance with one-beat records covers seq wrap.
module tb_difftest_axis_packer;

    localparam int IW  = 4064;
    localparam int AW  = 512;
    localparam int IW2 = 480;

    logic clk = 0, rst_n = 0, rst2_n = 0;
    always #5 clk = ~clk;

    logic in_valid = 0, flush = 0, tready = 1, rnd = 0;
    logic [IW-1:0] in_data = '0;
    logic in_ready, tvalid, tlast, busy;
    logic [AW-1:0] tdata;
    logic [AW/8-1:0] tkeep;
    logic [31:0] pkt_count;

    logic in_valid2 = 1, flush2 = 0, tready2 = 1, done2 = 0;
    logic [IW2-1:0] in_data2 = '0;
    logic in_ready2, tvalid2, tlast2, busy2;
    logic [AW-1:0] tdata2;
    logic [AW/8-1:0] tkeep2;
    logic [31:0] pkt_count2;

    difftest_axis_packer dut (
        .xdma_clk(clk), .xdma_resetn(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .m_axis_c2h_tdata_0(tdata), .m_axis_c2h_tkeep_0(tkeep),
        .m_axis_c2h_tlast_0(tlast), .m_axis_c2h_tvalid_0(tvalid), .m_axis_c2h_tready_0(tready),
        .pkt_count(pkt_count), .busy(busy)
    );

    difftest_axis_packer #(.IN_WIDTH(IW2), .PKTS_PER_XFER(1)) dut2 (
        .xdma_clk(clk), .xdma_resetn(rst2_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .flush(flush2), .m_axis_c2h_tdata_0(tdata2), .m_axis_c2h_tkeep_0(tkeep2),
        .m_axis_c2h_tlast_0(tlast2), .m_axis_c2h_tvalid_0(tvalid2), .m_axis_c2h_tready_0(tready2),
        .pkt_count(pkt_count2), .busy(busy2)
    );

    logic [AW-1:0] exp_q[$];
    int chk_s = 0, fail_s = 0, chk_m = 0, fail_m = 0, chk_2 = 0, fail_2 = 0;
    int done_cnt = 0, hs_cnt = 0, tlast_cnt = 0, grp_m = 0, beat_m = 0;
    int acc_cnt = 0, acc_base = 0, flush_req = 0, flush_seen = 0;
    logic [15:0] seq_m = 0;
    logic prev_stall = 0, prev_last = 0;
    logic [AW-1:0] prev_data = '0;

    task automatic chk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        chk_s++;
        if (got !== exp) begin
            fail_s++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic mchk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        chk_m++;
        if (got !== exp) begin
            fail_m++;
            $display("FAIL %s: got %0h expected %0h (record %0d beat %0d)", nm, got, exp, done_cnt, beat_m);
        end
    endtask

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] r;
        for (int i = 0; i < IW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [IW2-1:0] rand_data2();
        logic [IW2-1:0] r;
        for (int i = 0; i < IW2 / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Offer one record; returns one cycle after the accepting edge with the beats queued.
    task automatic push(input logic [IW-1:0] d);
        logic [IW+31:0] p;
        int n = 0;
        in_valid = 1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", in_ready, 1);
        p = {d, 16'hDA7A, seq_m};
        for (int i = 0; i < 8; i++) exp_q.push_back(p[AW*i +: AW]);
        seq_m++;
        @(posedge clk); #1;
        acc_cnt++;
        in_valid = 0;
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while ((done_cnt != n || tvalid) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_records", done_cnt, n);
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; flush = 0; rnd = 0; seq_m = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial forever begin
        @(posedge clk); #1;
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: occupancy model for in_ready/busy, stall stability, beat scoreboard, group/flush model for tlast.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            done_cnt = 0; hs_cnt = 0; tlast_cnt = 0; grp_m = 0; beat_m = 0;
            prev_stall = 0; acc_base = acc_cnt; flush_seen = flush_req;
        end else begin
            int occ;
            logic exp_last;
            occ = acc_cnt - acc_base - done_cnt;
            mchk("in_ready", in_ready, occ < 2);
            mchk("busy", busy, occ > 0);
            mchk("tkeep", tkeep, {(AW/8){tvalid}});
            if (prev_stall) begin
                mchk("stall_valid", tvalid, 1);
                mchk("stall_data", tdata, prev_data);
                mchk("stall_last", tlast, prev_last);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (tvalid && tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) mchk("unexpected_beat", tdata, 'x);
                else mchk("tdata", tdata, exp_q.pop_front());
                exp_last = beat_m == 7 && (grp_m == 7 || flush_req != flush_seen);
                mchk("tlast", tlast, exp_last);
                if (tlast) tlast_cnt++;
                if (beat_m == 7) begin
                    done_cnt++;
                    beat_m = 0;
                    if (exp_last) begin
                        grp_m = 0;
                        flush_seen = flush_req;
                    end else grp_m++;
                end else beat_m++;
            end
        end
    end

    // One-beat records, continuous traffic: header seq must wrap FFFF -> 0000 with MAGIC intact.
    initial begin
        logic [IW2-1:0] q2[$];
        logic [AW-1:0] exp2;
        logic [15:0] s2 = 0;
        int n2 = 0, cyc2 = 0;
        repeat (3) @(posedge clk);
        #1 rst2_n = 1;
        in_data2 = rand_data2();
        while (n2 < 65538 && cyc2 < 70000) begin
            @(negedge clk);
            cyc2++;
            if (tvalid2) begin
                exp2 = q2.size() > 0 ? {q2.pop_front(), 16'hDA7A, s2} : 'x;
                chk_2++;
                if (tdata2 !== exp2 || tlast2 !== 1'b1) begin
                    fail_2++;
                    $display("FAIL wrap_record %0d: got last=%b data=%0h expected last=1 data=%0h", n2, tlast2, tdata2, exp2);
                end
                if (n2 == 65535 || n2 == 65536) begin
                    chk_2++;
                    if (tdata2[31:0] !== (n2 == 65535 ? 32'hDA7AFFFF : 32'hDA7A0000)) begin
                        fail_2++;
                        $display("FAIL seq_wrap_header %0d: got %h", n2, tdata2[31:0]);
                    end
                end
                n2++;
                s2++;
            end
            if (in_ready2) q2.push_back(in_data2);
            @(posedge clk); #1;
            in_data2 = rand_data2();
        end
        chk_2++;
        if (n2 < 65538) begin
            fail_2++;
            $display("FAIL wrap_timeout: got %0d records expected 65538", n2);
        end
        done2 = 1;
    end

    initial begin
        int c;
        logic [IW-1:0] pat_a;
        // Reset values and single record latency
        do_reset();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        for (int i = 0; i < IW / 32; i++) pat_a[32*i +: 32] = 32'hA5A50000 + i;
        push(pat_a);
        chk("t1_latency", tvalid, 1);
        chk("t1_hdr", tdata[31:0], 32'hDA7A0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_beat_valid", tvalid, 1);
        end
        @(negedge clk);
        chk("t1_end_valid", tvalid, 0);
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_no_tlast", tlast_cnt, 0);

        // 16 back-to-back records: 128 contiguous beats
        do_reset();
        fork
            begin
                for (int i = 0; i < 16; i++) push(rand_data());
            end
        join_none
        c = 0;
        while (!tvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 128; i++) begin
            chk("t2_contiguous", tvalid, 1);
            @(negedge clk);
        end
        chk("t2_idle_after", tvalid, 0);
        wait_done(16);
        chk("t2_tlast_cnt", tlast_cnt, 2);
        chk("t2_pkt_count", pkt_count, 16);

        // Random backpressure with continuous input
        do_reset();
        rnd = 1;
        for (int i = 0; i < 24; i++) push(rand_data());
        wait_done(24);
        rnd = 0;
        chk("t3_pkt_count", pkt_count, 24);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Early flush on the third record, then a full group of eight
        do_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) push(rand_data());
            end
        join_none
        c = 0;
        while (done_cnt < 2 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (2) @(posedge clk);
        #1 flush = 1;
        flush_req++;
        @(posedge clk);
        #1 flush = 0;
        wait_done(3);
        chk("t4_flush_tlast", tlast_cnt, 1);
        for (int i = 0; i < 8; i++) push(rand_data());
        wait_done(11);
        chk("t4_group_tlast", tlast_cnt, 2);
        chk("t4_pkt_count", pkt_count, 11);

        // Asynchronous reset in the middle of a burst
        do_reset();
        push(rand_data());
        push(rand_data());
        c = 0;
        while (hs_cnt < 4 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t6_at_beat4", hs_cnt, 4);
        rst_n = 0;
        #1;
        chk("t6_async_tvalid", tvalid, 0);
        chk("t6_async_tlast", tlast, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_in_ready", in_ready, 1);
        seq_m = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        push(rand_data());
        chk("t6_restart_hdr", tdata[31:0], 32'hDA7A0000);
        chk("t6_restart_count", pkt_count, 0);
        wait_done(1);
        chk("t6_pkt_count", pkt_count, 1);

        c = 0;
        while (!done2 && c < 80000) begin
            @(posedge clk);
            c++;
        end
        chk("wrap_finished", done2, 1);
        $display("%0d/%0d checks passed", (chk_s + chk_m + chk_2) - (fail_s + fail_m + fail_2), chk_s + chk_m + chk_2);
        $finish;
    end

endmodule
